keccak_req_scheduler: RTL

// - Shares one 512-bit Keccak hash core between NREQ message requesters.
// - Grants the core one whole message at a time, round-robin.
// - Streams the granted message's 64-bit words into the core, generating is_last/byte_num and inserting the pad word.
// - Captures the digest, returns it to the owning requester, then resets the core ready for the next message.

---
 rtl/keccak_req_scheduler_pkg.sv | 29 ++
 rtl/keccak_req_scheduler_if.sv | 44 ++++
 rtl/keccak_req_scheduler_arbiter.sv | 29 ++
 rtl/keccak_req_scheduler.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/keccak_req_scheduler_pkg.sv
// Shared constants, state encodings and core beat payload for the Keccak request scheduler.
package keccak_sched_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned DIGEST_W   = 512;
  localparam int unsigned BYTES_W    = 4;
  localparam int unsigned BYTE_NUM_W = 3;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_CORE_RST = 3'd0;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd1;
  localparam logic [STATE_W-1:0] ST_FEED     = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAD      = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_OUT = 3'd4;
  localparam logic [STATE_W-1:0] ST_DELIVER  = 3'd5;

  // One word presented to the hash core
  typedef struct packed {
    logic [WORD_W-1:0]     data;
    logic                  is_last;
    logic [BYTE_NUM_W-1:0] byte_num;
  } core_beat_t;

  // Byte counts above a full word are treated as a full word
  function automatic logic [BYTES_W-1:0] clamp_bytes(input logic [BYTES_W-1:0] b);
    return (b > BYTES_W'(8)) ? BYTES_W'(8) : b;
  endfunction

endpackage

// File: rtl/keccak_req_scheduler_if.sv
// Requester, digest and hash-core signals of the scheduler bundled as one interface.
interface keccak_req_scheduler_if #(
  parameter int unsigned NREQ = 2
);
  import keccak_sched_pkg::*;

  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WORD_W-1:0]  req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ*BYTES_W-1:0] req_bytes;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         dig_valid;
  logic [NREQ-1:0]         dig_ack;
  logic [DIGEST_W-1:0]     dig_data;
  logic                    core_reset;
  logic [WORD_W-1:0]       core_in;
  logic                    core_in_ready;
  logic                    core_is_last;
  logic [BYTE_NUM_W-1:0]   core_byte_num;
  logic                    core_buffer_full;
  logic                    core_out_ready;
  logic [DIGEST_W-1:0]     core_out;
  logic                    busy;
  logic [ID_W-1:0]         grant_id;

  // Requesters plus hash core, seen from outside the scheduler
  modport master (
    output req_valid, req_data, req_last, req_bytes, dig_ack,
           core_buffer_full, core_out_ready, core_out,
    input  req_ready, dig_valid, dig_data, core_reset, core_in, core_in_ready,
           core_is_last, core_byte_num, busy, grant_id
  );

  // The scheduler itself
  modport slave (
    input  req_valid, req_data, req_last, req_bytes, dig_ack,
           core_buffer_full, core_out_ready, core_out,
    output req_ready, dig_valid, dig_data, core_reset, core_in, core_in_ready,
           core_is_last, core_byte_num, busy, grant_id
  );

endinterface

// File: rtl/keccak_req_scheduler_arbiter.sv
// Round-robin pick: first active request strictly after the previous winner, with wrap.
module keccak_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  // Scan NREQ positions starting at ptr_i+1; keep the first hit
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned     j;
      logic [ID_W-1:0] jj;
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = ID_W'(j);
      if (!any_o && req_i[jj]) begin
        any_o = 1'b1;
        idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/keccak_req_scheduler.sv
// Shares one Keccak core between NREQ requesters: whole-message round-robin grant,
// word streaming with pad insertion, digest capture/return and core reset between messages.
module keccak_req_scheduler
  import keccak_sched_pkg::*;
#(
  parameter int unsigned NREQ            = 2,
  parameter int unsigned CORE_RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  keccak_req_scheduler_if.slave bus
);

  localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(CORE_RST_CYCLES - 1);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     dig_valid_q, dig_valid_d;
  logic [DIGEST_W-1:0] dig_data_q, dig_data_d;
  logic                core_reset_q, core_reset_d;
  logic                busy_q, busy_d;

  logic [NREQ-1:0]     req_ready_c;
  logic                core_in_ready_c;
  logic                xfer_c;
  core_beat_t          beat_c;

  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;

  logic                g_valid, g_last;
  logic [WORD_W-1:0]   g_data;
  logic [BYTES_W-1:0]  g_bytes;

  keccak_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Granted requester's word, last flag and clamped byte count
  assign g_valid = bus.req_valid[grant_q];
  assign g_last  = bus.req_last[grant_q];
  assign g_data  = bus.req_data[int'(grant_q) * int'(WORD_W) +: WORD_W];
  assign g_bytes = clamp_bytes(bus.req_bytes[int'(grant_q) * int'(BYTES_W) +: BYTES_W]);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CORE_RST;
      rst_cnt_q    <= RST_LOAD;
      grant_q      <= '0;
      rr_ptr_q     <= ID_W'(NREQ - 1);
      dig_valid_q  <= '0;
      dig_data_q   <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      dig_valid_q  <= dig_valid_d;
      dig_data_q   <= dig_data_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic and the zero-latency feed path
  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    dig_valid_d     = dig_valid_q;
    dig_data_d      = dig_data_q;
    req_ready_c     = '0;
    xfer_c          = 1'b0;
    core_in_ready_c = 1'b0;
    beat_c          = '0;

    case (state_q)
      ST_CORE_RST: begin
        if (rst_cnt_q == '0) state_d = ST_IDLE;
        else                 rst_cnt_d = rst_cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
        if (arb_any) begin
          grant_d  = arb_idx;
          rr_ptr_d = arb_idx;
          state_d  = ST_FEED;
        end
      end
      ST_FEED: begin
        req_ready_c[grant_q] = !bus.core_buffer_full;
        xfer_c               = g_valid && !bus.core_buffer_full;
        core_in_ready_c      = xfer_c;
        beat_c.data          = g_data;
        if (xfer_c && g_last) begin
          if (g_bytes == BYTES_W'(8)) begin
            state_d = ST_PAD;
          end else begin
            beat_c.is_last  = 1'b1;
            beat_c.byte_num = g_bytes[BYTE_NUM_W-1:0];
            state_d         = ST_WAIT_OUT;
          end
        end
      end
      ST_PAD: begin
        if (!bus.core_buffer_full) begin
          core_in_ready_c = 1'b1;
          beat_c.is_last  = 1'b1;
          state_d         = ST_WAIT_OUT;
        end
      end
      ST_WAIT_OUT: begin
        if (bus.core_out_ready) begin
          dig_data_d           = bus.core_out;
          dig_valid_d[grant_q] = 1'b1;
          state_d              = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (bus.dig_ack[grant_q]) begin
          dig_valid_d = '0;
          rst_cnt_d   = RST_LOAD;
          state_d     = ST_CORE_RST;
        end
      end
      default: begin
        rst_cnt_d = RST_LOAD;
        state_d   = ST_CORE_RST;
      end
    endcase

    core_reset_d = (state_d == ST_CORE_RST);
    busy_d       = (state_d != ST_IDLE);
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.core_in_ready = core_in_ready_c;
  assign bus.core_in       = beat_c.data;
  assign bus.core_is_last  = beat_c.is_last;
  assign bus.core_byte_num = beat_c.byte_num;
  assign bus.dig_valid     = dig_valid_q;
  assign bus.dig_data      = dig_data_q;
  assign bus.core_reset    = core_reset_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_q;

endmodule
